// File: rtl/life_core_if.sv
// Host-side bundle for life_core.
//
// Carries the command pulses (step / randomize_cmd / clear), the LFSR seed,
// the rule inputs (wrap, birth_mask, survive_mask), the single-cell host
// write port, the display read port and the status outputs (busy, done,
// gen_count, pop_count).
//
//   master : host / display side (drives commands, writes, read address)
//   slave  : life_core side (drives rd_cell and status)
interface life_core_if #(
  parameter int LOG_W = 5,
  parameter int LOG_H = 4
);
  logic                   step;
  logic                   randomize_cmd;
  logic                   clear;
  logic [15:0]            seed;
  logic                   wrap;
  logic [8:0]             birth_mask;
  logic [8:0]             survive_mask;
  logic                   wr_en;
  logic [LOG_W-1:0]       wr_x;
  logic [LOG_H-1:0]       wr_y;
  logic                   wr_data;
  logic [LOG_W-1:0]       rd_x;
  logic [LOG_H-1:0]       rd_y;
  logic                   rd_cell;
  logic                   busy;
  logic                   done;
  logic [15:0]            gen_count;
  logic [LOG_W+LOG_H:0]   pop_count;

  modport master (
    output step, randomize_cmd, clear, seed, wrap, birth_mask, survive_mask,
    output wr_en, wr_x, wr_y, wr_data, rd_x, rd_y,
    input  rd_cell, busy, done, gen_count, pop_count
  );

  modport slave (
    input  step, randomize_cmd, clear, seed, wrap, birth_mask, survive_mask,
    input  wr_en, wr_x, wr_y, wr_data, rd_x, rd_y,
    output rd_cell, busy, done, gen_count, pop_count
  );
endinterface

// File: rtl/life_core.sv
// Sequential cellular-automaton engine (Life-like rules, configurable B/S).
//
// Holds a current board and a next board of W*H one-bit cells (index
// y*W + x). One cell is touched per clock: clearing, LFSR fill, neighbour
// accumulation (9 cycles per cell) and copy-back (1 cycle per cell).
//
// Ports:
//   clk    : single clock, all state on rising edge
//   rst_n  : synchronous active-low reset; starts a board clear
//   bus    : life_core_if.slave -- commands, rules, host write port,
//            display read port (rd_cell is combinational), busy/done,
//            gen_count, pop_count
module life_core #(
  parameter int LOG_W = 5,
  parameter int LOG_H = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  life_core_if.slave   bus
);

  localparam int W  = 1 << LOG_W;
  localparam int H  = 1 << LOG_H;
  localparam int N  = W * H;
  localparam int IW = LOG_W + LOG_H;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT_CLR = 3'd1,
    INIT_RND = 3'd2,
    UPDATE   = 3'd3,
    COPY     = 3'd4
  } state_t;

  state_t          state_r;
  logic [N-1:0]    cur_r;
  logic [N-1:0]    nxt_r;
  logic [IW-1:0]   idx_r;
  logic [3:0]      phase_r;
  logic [3:0]      cnt_r;
  logic [IW:0]     acc_r;
  logic [15:0]     lfsr_r;
  logic            wrap_r;
  logic [8:0]      birth_r;
  logic [8:0]      survive_r;
  logic            done_r;
  logic [15:0]     gen_r;
  logic [IW:0]     pop_r;

  logic [3:0]      off_s;
  logic [LOG_W:0]  nx_s;
  logic [LOG_H:0]  ny_s;
  logic            in_board_s;
  logic            nbr_s;
  logic            cell_next_s;
  logic            lfsr_fb_s;

  // Neighbour offset for accumulation phase ph, packed {dx[1:0], dy[1:0]}
  // as two's complement values in -1..+1.
  function automatic logic [3:0] nbr_offset(input logic [3:0] ph);
    logic [3:0] off;
    case (ph)
      4'd0:    off = {2'b11, 2'b01};
      4'd1:    off = {2'b00, 2'b01};
      4'd2:    off = {2'b01, 2'b01};
      4'd3:    off = {2'b11, 2'b00};
      4'd4:    off = {2'b01, 2'b00};
      4'd5:    off = {2'b11, 2'b11};
      4'd6:    off = {2'b00, 2'b11};
      4'd7:    off = {2'b01, 2'b11};
      default: off = 4'b0000;
    endcase
    return off;
  endfunction

  // Neighbour fetch, next-state rule lookup and LFSR feedback.
  always_comb begin
    off_s = nbr_offset(phase_r);
    // One extra bit catches both -1 and W (resp. H): either sets the top bit.
    nx_s = {1'b0, idx_r[LOG_W-1:0]} + {{(LOG_W-1){off_s[3]}}, off_s[3:2]};
    ny_s = {1'b0, idx_r[IW-1:LOG_W]} + {{(LOG_H-1){off_s[1]}}, off_s[1:0]};
    in_board_s = ~nx_s[LOG_W] & ~ny_s[LOG_H];
    // Dropping the top bit gives the modulo-W/H coordinate for wrap mode.
    nbr_s = cur_r[{ny_s[LOG_H-1:0], nx_s[LOG_W-1:0]}] & (wrap_r | in_board_s);
    if (cur_r[idx_r]) begin
      cell_next_s = survive_r[cnt_r];
    end else begin
      cell_next_s = birth_r[cnt_r];
    end
    lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
  end

  // Engine FSM: command acceptance, board sweeps and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= INIT_CLR;
      idx_r     <= '0;
      phase_r   <= 4'd0;
      cnt_r     <= 4'd0;
      acc_r     <= '0;
      done_r    <= 1'b0;
      gen_r     <= 16'd0;
      pop_r     <= '0;
      lfsr_r    <= 16'hACE1;
      wrap_r    <= 1'b0;
      birth_r   <= 9'd0;
      survive_r <= 9'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          idx_r   <= '0;
          phase_r <= 4'd0;
          cnt_r   <= 4'd0;
          acc_r   <= '0;
          if (bus.clear) begin
            state_r <= INIT_CLR;
          end else if (bus.randomize_cmd) begin
            state_r <= INIT_RND;
            lfsr_r  <= (bus.seed == 16'h0000) ? 16'hACE1 : bus.seed;
          end else if (bus.step) begin
            state_r   <= UPDATE;
            wrap_r    <= bus.wrap;
            birth_r   <= bus.birth_mask;
            survive_r <= bus.survive_mask;
          end else if (bus.wr_en) begin
            cur_r[{bus.wr_y, bus.wr_x}] <= bus.wr_data;
          end
        end

        INIT_CLR: begin
          cur_r[idx_r] <= 1'b0;
          if (idx_r == LAST_IDX) begin
            state_r <= IDLE;
            done_r  <= 1'b1;
            gen_r   <= 16'd0;
            pop_r   <= '0;
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end

        INIT_RND: begin
          cur_r[idx_r] <= lfsr_r[0];
          lfsr_r       <= {lfsr_r[14:0], lfsr_fb_s};
          acc_r        <= acc_r + {{IW{1'b0}}, lfsr_r[0]};
          if (idx_r == LAST_IDX) begin
            state_r <= IDLE;
            done_r  <= 1'b1;
            gen_r   <= 16'd0;
            pop_r   <= acc_r + {{IW{1'b0}}, lfsr_r[0]};
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end

        UPDATE: begin
          if (phase_r == 4'd8) begin
            nxt_r[idx_r] <= cell_next_s;
            cnt_r        <= 4'd0;
            phase_r      <= 4'd0;
            if (idx_r == LAST_IDX) begin
              state_r <= COPY;
              idx_r   <= '0;
              acc_r   <= '0;
            end else begin
              idx_r <= idx_r + 1'b1;
            end
          end else begin
            cnt_r   <= cnt_r + {3'd0, nbr_s};
            phase_r <= phase_r + 4'd1;
          end
        end

        COPY: begin
          cur_r[idx_r] <= nxt_r[idx_r];
          acc_r        <= acc_r + {{IW{1'b0}}, nxt_r[idx_r]};
          if (idx_r == LAST_IDX) begin
            state_r <= IDLE;
            done_r  <= 1'b1;
            gen_r   <= gen_r + 16'd1;
            pop_r   <= acc_r + {{IW{1'b0}}, nxt_r[idx_r]};
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end

        default: begin
          state_r <= INIT_CLR;
          idx_r   <= '0;
        end
      endcase
    end
  end

  assign bus.rd_cell   = cur_r[{bus.rd_y, bus.rd_x}];
  assign bus.busy      = (state_r != IDLE);
  assign bus.done      = done_r;
  assign bus.gen_count = gen_r;
  assign bus.pop_count = pop_r;

endmodule

// File: tb/tb_life_core.sv
// Scoreboard bench for life_core: stimulus pushes expected results computed
// by a 2-D board model; a monitor pops one entry per done pulse and checks
// busy length, counters and the full board read back through rd_cell.
module tb_life_core;
  localparam int LOG_W = 5;
  localparam int LOG_H = 4;
  localparam int W = 32;
  localparam int H = 16;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  life_core_if #(.LOG_W(LOG_W), .LOG_H(LOG_H)) bus ();
  life_core #(.LOG_W(LOG_W), .LOG_H(LOG_H)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int          busy_cyc;
    int          gen;
    int          pop;
    logic [N-1:0] brd;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           n_done = 0;
  logic [N-1:0] scan_brd;
  bit           mdl [H][W];
  int           m_gen = 0;

  task automatic check(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] pack_mdl();
    logic [N-1:0] b;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        b[y*W + x] = mdl[y][x];
    return b;
  endfunction

  function automatic int pop_mdl();
    int p = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        p += int'(mdl[y][x]);
    return p;
  endfunction

  task automatic mdl_zero();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        mdl[y][x] = 1'b0;
    m_gen = 0;
  endtask

  task automatic mdl_step(input bit wr, input logic [8:0] b, input logic [8:0] s);
    bit nb [H][W];
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int xx = x + dx;
            int yy = y + dy;
            if (dx != 0 || dy != 0) begin
              if (wr) n += int'(mdl[(yy + H) % H][(xx + W) % W]);
              else if (xx >= 0 && xx < W && yy >= 0 && yy < H) n += int'(mdl[yy][xx]);
            end
          end
        end
        nb[y][x] = mdl[y][x] ? s[n] : b[n];
      end
    end
    mdl = nb;
    m_gen = (m_gen + 1) & 32'hFFFF;
  endtask

  task automatic mdl_lfsr(input logic [15:0] sd);
    logic [15:0] l;
    l = (sd == 16'h0000) ? 16'hACE1 : sd;
    for (int i = 0; i < N; i++) begin
      mdl[i / W][i % W] = l[0];
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    m_gen = 0;
  endtask

  task automatic push_exp(input int busy_cyc);
    exp_t e;
    e.busy_cyc = busy_cyc;
    e.gen      = m_gen;
    e.pop      = pop_mdl();
    e.brd      = pack_mdl();
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  task automatic scan();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        bus.rd_x = LOG_W'(x);
        bus.rd_y = LOG_H'(y);
        #1;
        scan_brd[y*W + x] = bus.rd_cell;
      end
    end
  endtask

  function automatic int count_diff(input logic [N-1:0] a, input logic [N-1:0] b);
    int d = 0;
    for (int i = 0; i < N; i++) if (a[i] !== b[i]) d++;
    return d;
  endfunction

  initial begin : monitor
    int   run;
    exp_t e;
    run = 0;
    bus.rd_x = '0;
    bus.rd_y = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        run = 0;
      end else if (bus.busy === 1'b1) begin
        run++;
      end else if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("busy_cycles", run, e.busy_cyc);
          check("gen_count", longint'(bus.gen_count), e.gen);
          check("pop_count", longint'(bus.pop_count), e.pop);
          scan();
          check("board_mismatch_cells", count_diff(scan_brd, e.brd), 0);
        end
        run = 0;
        n_done++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input int budget);
    int tgt;
    tgt = n_done + 1;
    for (int i = 0; i < budget && n_done < tgt; i++) @(posedge clk);
    check("done_within_budget", (n_done >= tgt) ? 1 : 0, 1);
  endtask

  task automatic issue(input bit c, input bit r, input bit s, input bit w);
    @(posedge clk); #2;
    bus.clear = c; bus.randomize_cmd = r; bus.step = s; bus.wr_en = w;
    @(posedge clk); #2;
    bus.clear = 1'b0; bus.randomize_cmd = 1'b0; bus.step = 1'b0; bus.wr_en = 1'b0;
  endtask

  task automatic write_cell(input int x, input int y, input bit d);
    bus.wr_x = LOG_W'(x); bus.wr_y = LOG_H'(y); bus.wr_data = d;
    issue(1'b0, 1'b0, 1'b0, 1'b1);
    mdl[y][x] = d;
  endtask

  task automatic do_clear();
    mdl_zero();
    push_exp(N);
    issue(1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(2 * N + 200);
  endtask

  task automatic do_rand(input logic [15:0] sd);
    bus.seed = sd;
    mdl_lfsr(sd);
    push_exp(N);
    issue(1'b0, 1'b1, 1'b0, 1'b0);
    bus.seed = 16'($urandom);
    wait_done(2 * N + 200);
  endtask

  // poke: while busy, pulse every command plus a write; all must be ignored.
  task automatic do_step(input bit wr, input logic [8:0] b, input logic [8:0] s, input bit poke);
    bus.wrap = wr; bus.birth_mask = b; bus.survive_mask = s;
    mdl_step(wr, b, s);
    push_exp(10 * N);
    issue(1'b0, 1'b0, 1'b1, 1'b0);
    bus.wrap = 1'($urandom); bus.birth_mask = 9'($urandom); bus.survive_mask = 9'($urandom);
    if (poke) begin
      repeat ($urandom_range(10, 4000)) @(posedge clk);
      bus.wr_x = 5'($urandom); bus.wr_y = 4'($urandom); bus.wr_data = 1'b1;
      issue(1'b1, 1'b1, 1'b1, 1'b1);
    end
    wait_done(11 * N + 200);
  endtask

  task automatic glider(input int ox, input int oy);
    write_cell((ox + 1) % W, oy % H, 1'b1);
    write_cell((ox + 2) % W, (oy + 1) % H, 1'b1);
    write_cell(ox % W, (oy + 2) % H, 1'b1);
    write_cell((ox + 1) % W, (oy + 2) % H, 1'b1);
    write_cell((ox + 2) % W, (oy + 2) % H, 1'b1);
  endtask

  initial begin : stimulus
    logic [N-1:0] brd_a;
    logic [N-1:0] brd_b;
    bus.step = 1'b0; bus.randomize_cmd = 1'b0; bus.clear = 1'b0; bus.seed = 16'h0000;
    bus.wrap = 1'b0; bus.birth_mask = 9'd0; bus.survive_mask = 9'd0;
    bus.wr_en = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = 1'b0;

    // Reset: clear sweep of N cycles, commands during it ignored.
    rst_n = 1'b0;
    mdl_zero();
    push_exp(N);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", bus.busy, 1);
    check("reset_done", bus.done, 0);
    check("reset_gen", bus.gen_count, 0);
    check("reset_pop", bus.pop_count, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    bus.wr_x = 5'd3; bus.wr_y = 4'd3; bus.wr_data = 1'b1;
    issue(1'b0, 1'b0, 1'b1, 1'b1);
    wait_done(2 * N + 200);

    // Blinker, no wrap, B3/S23.
    write_cell(15, 7, 1'b1);
    write_cell(16, 7, 1'b1);
    write_cell(17, 7, 1'b1);
    do_step(1'b0, 9'h008, 9'h00C, 1'b1);
    check("blinker_pop_3", pop_mdl(), 3);

    // Glider straddling both edges with wrap: four steps move it by (1,1).
    do_clear();
    glider(30, 14);
    for (int i = 0; i < 4; i++) do_step(1'b1, 9'h008, 9'h00C, 1'b0);

    // Glider pressed into the bottom-right corner without wrap.
    do_clear();
    glider(29, 13);
    for (int i = 0; i < 2; i++) do_step(1'b0, 9'h008, 9'h00C, 1'b0);

    // Seed 0 maps to ACE1; seed 1 gives a different board.
    do_rand(16'h0000);
    brd_a = scan_brd;
    do_rand(16'hACE1);
    brd_b = scan_brd;
    check("seed0_vs_ace1_diff_cells", count_diff(brd_a, brd_b), 0);
    do_rand(16'h0001);
    check("seed1_differs", (count_diff(scan_brd, brd_b) != 0) ? 1 : 0, 1);

    // Random board, random rules and edge mode, rules scrambled mid-step.
    do_rand(16'($urandom));
    for (int i = 0; i < 2; i++)
      do_step(1'($urandom), 9'($urandom), 9'($urandom), 1'b1);

    // randomize beats step; the write in the same cycle is dropped.
    bus.seed = 16'h1234; bus.wr_x = 5'd0; bus.wr_y = 4'd0; bus.wr_data = ~mdl[0][0];
    mdl_lfsr(16'h1234);
    push_exp(N);
    issue(1'b0, 1'b1, 1'b1, 1'b1);
    wait_done(2 * N + 200);

    // clear beats both; commands and writes during the sweep are ignored.
    mdl_zero();
    push_exp(N);
    issue(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (100) @(posedge clk);
    bus.wr_x = 5'd9; bus.wr_y = 4'd9; bus.wr_data = 1'b1;
    issue(1'b0, 1'b1, 1'b1, 1'b1);
    wait_done(2 * N + 200);

    // Empty board, B0 without wrap: every cell is born.
    do_step(1'b0, 9'h001, 9'h000, 1'b0);
    check("all_born_pop", pop_mdl(), N);

    // Reset in the middle of an UPDATE sweep aborts it.
    bus.wrap = 1'b1; bus.birth_mask = 9'h008; bus.survive_mask = 9'h00C;
    issue(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2000) @(posedge clk);
    #2;
    mdl_zero();
    push_exp(N);
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_busy", bus.busy, 1);
    check("midreset_gen", bus.gen_count, 0);
    wait_done(2 * N + 200);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/life_core.md
LIFE_CORE -- requirements
Module: life_core

Interface
REQ-001 SHALL have parameter LOG_W, 5, log2 of board width W.
REQ-002 SHALL have parameter LOG_H, 4, log2 of board height H; N = W*H cells.
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock, all state on rising edge
  rst_n  in  1  reset, synchronous, active-low
  step  in  1  pulse: compute one generation
  randomize  in  1  pulse: fill board from LFSR
  clear  in  1  pulse: set all cells dead
  seed  in  16  LFSR seed
  wrap  in  1  1 = toroidal edges; 0 = out-of-board neighbours dead
  birth_mask  in  9  bit k=1: dead cell with k live neighbours is born
  survive_mask  in  9  bit k=1: live cell with k live neighbours survives
  wr_en  in  1  host cell write
  wr_x  in  LOG_W  write column
  wr_y  in  LOG_H  write row
  wr_data  in  1  write value
  rd_x  in  LOG_W  display read column
  rd_y  in  LOG_H  display read row
  rd_cell  out  1  current-board cell at (rd_x, rd_y), combinational
  busy  out  1  engine not IDLE
  done  out  1  one-cycle pulse when a command completes
  gen_count  out  16  generations since last clear/randomize
  pop_count  out  LOG_W+LOG_H+1  live cells after last completed step

Function
REQ-004 SHALL hold current board CUR[N] and next board NXT[N], 1 bit each, index = y*W + x.
REQ-005 SHALL implement FSM states IDLE, INIT_CLR, INIT_RND, UPDATE, COPY; busy = (state != IDLE).
REQ-006 In IDLE, commands accepted in priority clear > randomize > step; only the highest is taken; lower ones that cycle are dropped.
REQ-007 Commands and wr_en while busy SHALL be ignored (no queuing).
REQ-008 wr_en in IDLE with no command SHALL write CUR[wr_y*W+wr_x] <= wr_data; visible on rd_cell next cycle; wr_en with an accepted command is dropped.
REQ-009 INIT_CLR: one cell per cycle, index 0..N-1, CUR <= 0; N cycles; then IDLE, done=1, gen_count=0, pop_count=0.
REQ-010 INIT_RND: on acceptance LFSR <= seed (16'hACE1 if seed==0); each cycle CUR[i] <= LFSR[0], LFSR shifts left, feedback = L[15]^L[13]^L[12]^L[10]; LFSR static outside INIT_RND; N cycles; then IDLE, done=1, gen_count=0, pop_count = cells written 1.
REQ-011 On step acceptance wrap, birth_mask, survive_mask SHALL be latched; changes mid-step have no effect.
REQ-012 UPDATE: 9 cycles per cell: cycles 0-7 add neighbours (-1,+1),(0,+1),(+1,+1),(-1,0),(+1,0),(-1,-1),(0,-1),(+1,-1) into 4-bit count; cycle 8 writes NXT[i] = CUR[i] ? survive_mask[count] : birth_mask[count], clears count; 9N cycles total.
REQ-013 Neighbour coordinates: wrap=1 modulo W/H; wrap=0 any coordinate outside 0..W-1 / 0..H-1 contributes 0.
REQ-014 COPY: one cell per cycle CUR[i] <= NXT[i], counting live cells; N cycles; then IDLE, done=1, gen_count += 1 (wraps 16'hFFFF->0), pop_count = count.
REQ-015 Step latency: busy high 10N cycles from cycle after acceptance; done coincides with first IDLE cycle.
REQ-016 rd_cell SHALL read CUR at all times, including mid-COPY (partial update visible; tearing accepted).
REQ-017 No action other than REQ-008 writes CUR while IDLE.

Reset
REQ-018 rst_n=0 at a clock edge: state<=INIT_CLR, index=0, count=0, done=0, gen_count=0, pop_count=0, LFSR<=16'hACE1, latched rules<=0, wrap latch<=0; aborts any operation.
REQ-019 After rst_n release, busy=1 for N cycles (board clear), then done=1, IDLE; no command accepted before.

Verification
REQ-020 Reset, wait done; write blinker (15,7),(16,7),(17,7), wrap=0, B=9'h008, S=9'h00C, step -> after 5120 cycles done; cells (16,6),(16,7),(16,8) live, rest dead, pop_count=3, gen_count=1.
REQ-021 Glider at origin, wrap=1, B3/S23, 128 steps -> glider back at original shape/position (32-cell wrap), pop_count=5, gen_count=128.
REQ-022 Same glider, wrap=0, steps until stable -> 2x2 block at bottom-right corner, pop_count=4; no wrap-around cells.
REQ-023 randomize with seed=0 vs seed=16'hACE1 -> identical boards; seed=16'h0001 -> different; pop_count equals sum of rd_cell over all cells.
REQ-024 step, clear, randomize same cycle -> clear taken, busy 512 cycles, all dead; step/wr_en pulsed while busy -> ignored, gen_count unchanged.
REQ-025 rst_n low mid-UPDATE (cycle 2000) -> next cycle busy=1 in INIT_CLR, gen_count=0; after 512 cycles all cells dead, done=1.
